// File: rtl/chronospatial_host_driver.sv
// Host-side driver for the 3-stage chronospatial core.
//
// Holds an 8-slot program and the A/B/C initial values. On start it shifts the
// registers into the core (MSB first), then serves opcode/operand fetches from
// the core's instruction pointer. Every emitted 3-bit value is captured into an
// output FIFO until the core halts.
//
// Optional feature: define CHRONO_WATCHDOG_EN to abort RUN after TIMEOUT cycles
// without a halt (sets the sticky timeout flag).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   prog_wr_en/addr/data       program write port ({operand, opcode}), IDLE/DONE only
//   reg_a/b/c_init             initial register values, sampled on start
//   start                      one-cycle start pulse (ignored while busy)
//   busy, done, timeout        status (busy = INIT or RUN)
//   out_rd_en, out_data        FIFO pop and first-word-fall-through head
//   out_empty, out_count       FIFO status
//   out_overflow               sticky: a value was dropped while the FIFO was full
//   core_ui, core_uo           core pins (uo: [2:0] value, [3] valid, [4] halt, [7:5] ip)
module chronospatial_host_driver #(
  parameter int unsigned REG_W     = 48,
  parameter int unsigned OUT_DEPTH = 16,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_wr_en,
  input  logic [2:0]                 prog_wr_addr,
  input  logic [5:0]                 prog_wr_data,
  input  logic [REG_W-1:0]           reg_a_init,
  input  logic [REG_W-1:0]           reg_b_init,
  input  logic [REG_W-1:0]           reg_c_init,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  input  logic                       out_rd_en,
  output logic [2:0]                 out_data,
  output logic                       out_empty,
  output logic [$clog2(OUT_DEPTH):0] out_count,
  output logic                       out_overflow,
  output logic [7:0]                 core_ui,
  input  logic [7:0]                 core_uo
);

  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned BitW = (REG_W > 1) ? $clog2(REG_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(REG_W - 1);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(OUT_DEPTH);

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("chronospatial_host_driver: OUT_DEPTH must be a power of 2 >= 2, TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [REG_W-1:0] a_sh_q, b_sh_q, c_sh_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic [5:0]       prog_mem_q [8];
  logic [2:0]       fifo_mem_q [OUT_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             overflow_q;
  logic             launch;
  logic             wd_expire;
  logic             push, pop, full, push_ok;
  logic [5:0]       fetch;

  // Next state and core pin drive.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    fetch   = prog_mem_q[core_uo[7:5]];
    core_ui = 8'h00;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StInit;
          launch  = 1'b1;
        end
      end
      StInit: begin
        core_ui = {5'b00001, c_sh_q[REG_W-1], b_sh_q[REG_W-1], a_sh_q[REG_W-1]};
        if (bit_cnt_q == LastBit) state_d = StRun;
      end
      StRun: begin
        // Zero-latency fetch: the core sees the instruction in the same cycle.
        core_ui = {1'b0, fetch[5:3], 1'b0, fetch[2:0]};
        if (core_uo[4] || wd_expire) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StInit) || (state_q == StRun);
  assign done = (state_q == StDone);

  // FIFO control. A pop at full frees the slot, so a simultaneous push is kept.
  assign full    = (count_q == FullCnt);
  assign push    = (state_q == StRun) && core_uo[3];
  assign pop     = out_rd_en && (count_q != '0);
  assign push_ok = push && (!full || pop);

  assign out_empty    = (count_q == '0);
  assign out_count    = count_q;
  assign out_overflow = overflow_q;
  assign out_data     = out_empty ? 3'b000 : fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      c_sh_q     <= '0;
      bit_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 8; i++) prog_mem_q[i] <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q <= state_d;

      if (prog_wr_en && !busy) prog_mem_q[prog_wr_addr] <= prog_wr_data;

      if (launch) begin
        a_sh_q    <= reg_a_init;
        b_sh_q    <= reg_b_init;
        c_sh_q    <= reg_c_init;
        bit_cnt_q <= '0;
      end else if (state_q == StInit) begin
        a_sh_q    <= a_sh_q << 1;
        b_sh_q    <= b_sh_q << 1;
        c_sh_q    <= c_sh_q << 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (launch) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok) begin
          fifo_mem_q[wr_ptr_q] <= core_uo[2:0];
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (push && !push_ok) overflow_q <= 1'b1;
      end
    end
  end

`ifdef CHRONO_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           timeout_q;

  // The counter holds the number of completed RUN cycles; it is zero on RUN entry.
  assign wd_expire = (state_q == StRun) && !core_uo[4] && (wd_cnt_q == WdW'(TIMEOUT - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StRun) wd_cnt_q <= wd_cnt_q + 1'b1;
      else                  wd_cnt_q <= '0;
      if (launch)         timeout_q <= 1'b0;
      else if (wd_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_chronospatial_host_driver.sv
// Self-checking bench for chronospatial_host_driver (REG_W=48, OUT_DEPTH=4, TIMEOUT=100).
// A small behavioural core model can drive core_uo; otherwise the bench drives it directly.
module tb_chronospatial_host_driver;

  localparam int unsigned RegW     = 48;
  localparam int unsigned OutDepth = 4;
  localparam int unsigned Timeout  = 100;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        prog_wr_en;
  logic [2:0]                  prog_wr_addr;
  logic [5:0]                  prog_wr_data;
  logic [RegW-1:0]             reg_a_init, reg_b_init, reg_c_init;
  logic                        start;
  logic                        busy, done, timeout;
  logic                        out_rd_en;
  logic [2:0]                  out_data;
  logic                        out_empty;
  logic [$clog2(OutDepth):0]   out_count;
  logic                        out_overflow;
  logic [7:0]                  core_ui;
  logic [7:0]                  core_uo;

  logic                        model_en;
  logic [7:0]                  tb_uo;
  logic [7:0]                  model_uo;

  always #5 clk = ~clk;

  assign core_uo = model_en ? model_uo : tb_uo;

  chronospatial_host_driver #(
    .REG_W    (RegW),
    .OUT_DEPTH(OutDepth),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_wr_en  (prog_wr_en),
    .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data),
    .reg_a_init  (reg_a_init),
    .reg_b_init  (reg_b_init),
    .reg_c_init  (reg_c_init),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .out_rd_en   (out_rd_en),
    .out_data    (out_data),
    .out_empty   (out_empty),
    .out_count   (out_count),
    .out_overflow(out_overflow),
    .core_ui     (core_ui),
    .core_uo     (core_uo)
  );

  // ---------------------------------------------------------------------------
  // Behavioural core: shifts A/B/C in while core_ui[3]=1, then executes one
  // instruction per cycle from core_ui; halts when the pointer runs past slot 7.
  // ---------------------------------------------------------------------------
  logic [RegW-1:0] ma, mb, mc, combo;
  logic [3:0]      mip, m_next_ip;
  logic            m_run, m_halt, m_ov;
  logic [2:0]      m_val, m_op, m_lit;

  always_comb begin
    m_op  = core_ui[2:0];
    m_lit = core_ui[6:4];
    case (m_lit)
      3'd4:    combo = ma;
      3'd5:    combo = mb;
      3'd6:    combo = mc;
      default: combo = RegW'(m_lit);
    endcase
    m_next_ip = (m_op == 3'd3 && ma != '0) ? {1'b0, m_lit} : mip + 4'd1;
  end

  assign model_uo = {mip[2:0], m_halt, m_ov, m_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0; mb <= '0; mc <= '0;
      mip <= '0; m_run <= 1'b0; m_halt <= 1'b0; m_ov <= 1'b0; m_val <= '0;
    end else if (core_ui[3]) begin
      ma <= {ma[RegW-2:0], core_ui[0]};
      mb <= {mb[RegW-2:0], core_ui[1]};
      mc <= {mc[RegW-2:0], core_ui[2]};
      mip <= '0; m_run <= 1'b1; m_halt <= 1'b0; m_ov <= 1'b0;
    end else if (m_run && !m_halt) begin
      m_ov   <= 1'b0;
      mip    <= m_next_ip;
      m_halt <= (m_next_ip == 4'd8);
      case (m_op)
        3'd0: ma <= ma >> combo;
        3'd1: mb <= mb ^ RegW'(m_lit);
        3'd2: mb <= RegW'(combo[2:0]);
        3'd3: ;
        3'd4: mb <= mb ^ mc;
        3'd5: begin m_val <= combo[2:0]; m_ov <= 1'b1; end
        3'd6: mb <= ma >> combo;
        3'd7: mc <= ma >> combo;
      endcase
    end else begin
      m_ov <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic prog_write(input logic [2:0] addr, input logic [5:0] data);
    @(negedge clk);
    prog_wr_en   = 1'b1;
    prog_wr_addr = addr;
    prog_wr_data = data;
    @(negedge clk);
    prog_wr_en   = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0] ip;
    logic [7:0] exp_ui;
  } fetch_vec_t;

  fetch_vec_t      fvec [8];
  logic [2:0]      exp_prog [10];
  logic [RegW-1:0] a_val;
  logic [7:0]      e_ui;
  logic            ok;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Fetch vectors: slot -> core_ui (= {0, operand, 0, opcode})
    fvec[0] = '{ip: 3'd5, exp_ui: 8'h37};
    fvec[1] = '{ip: 3'd0, exp_ui: 8'h10};
    fvec[2] = '{ip: 3'd1, exp_ui: 8'h45};
    fvec[3] = '{ip: 3'd2, exp_ui: 8'h03};
    fvec[4] = '{ip: 3'd3, exp_ui: 8'h00};
    fvec[5] = '{ip: 3'd7, exp_ui: 8'h00};
    fvec[6] = '{ip: 3'd4, exp_ui: 8'h00};
    fvec[7] = '{ip: 3'd6, exp_ui: 8'h00};
    exp_prog = '{3'd4, 3'd6, 3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0};

    rst_n = 1'b1; start = 1'b0; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
    reg_a_init = '0; reg_b_init = '0; reg_c_init = '0; out_rd_en = 1'b0;
    model_en = 1'b0; tb_uo = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overflow", out_overflow, 0);
    check("rst_count", out_count, 0);
    check("rst_empty", out_empty, 1);
    check("rst_data", out_data, 0);
    check("rst_core_ui", core_ui, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pop on empty has no effect
    out_rd_en = 1'b1;
    @(negedge clk);
    out_rd_en = 1'b0;
    check("empty_pop_count", out_count, 0);
    check("empty_pop_empty", out_empty, 1);

    // Program: adv 1, out 4, jnz 0, and slot 5 = {operand 3, opcode 7}
    prog_write(3'd0, 6'b001_000);
    prog_write(3'd1, 6'b100_101);
    prog_write(3'd2, 6'b000_011);
    prog_write(3'd5, 6'b011_111);

    // ---- Run 1: INIT shift, fetch mux, overflow, using a bench-driven core_uo
    a_val = RegW'(729);
    reg_a_init = a_val;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reg_a_init = '1;  // must not affect the load already sampled
    check("init_busy", busy, 1);
    for (int k = 0; k < int'(RegW); k++) begin
      e_ui = 8'h08 | {7'b0, a_val[RegW-1-k]};
      check("init_ui", core_ui, e_ui);
      @(negedge clk);
    end
    check("run_entry_ui", core_ui, 8'h10);
    check("run_busy", busy, 1);

    foreach (fvec[i]) begin
      tb_uo = {fvec[i].ip, 5'b0};
      #1;
      check("fetch_mux", core_ui, fvec[i].exp_ui);
      @(negedge clk);
    end

    // Writes while busy are ignored
    prog_wr_en = 1'b1; prog_wr_addr = 3'd5; prog_wr_data = 6'b000_000;
    @(negedge clk);
    prog_wr_en = 1'b0;
    tb_uo = {3'd5, 5'b0};
    #1;
    check("busy_write_ignored", core_ui, 8'h37);

    // Six outputs into a 4-deep FIFO
    for (int v = 1; v <= 6; v++) begin
      @(negedge clk);
      tb_uo = {3'd0, 1'b0, 1'b1, 3'(v)};
      if (sb.size() < int'(OutDepth)) sb.push_back(3'(v));
    end
    @(negedge clk);
    tb_uo = '0;
    check("ovf_count", out_count, OutDepth);
    check("ovf_flag", out_overflow, 1);
    check("ovf_head", out_data, sb[0]);

    // Push and pop together at full
    @(negedge clk);
    tb_uo = {3'd0, 1'b0, 1'b1, 3'd7};
    out_rd_en = 1'b1;
    check("pp_head", out_data, sb.pop_front());
    sb.push_back(3'd7);
    @(negedge clk);
    tb_uo = '0;
    check("pp_count", out_count, OutDepth);
    check("pp_new_head", out_data, sb[0]);
    check("pp_pop_again", out_data, sb.pop_front());

    // Halt with out_valid in the same cycle: value still captured
    @(negedge clk);
    out_rd_en = 1'b0;
    tb_uo = {3'd0, 1'b1, 1'b1, 3'd5};
    sb.push_back(3'd5);
    check("pre_halt_count", out_count, 3);
    @(negedge clk);
    tb_uo = '0;
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_core_ui", core_ui, 0);
    check("halt_count", out_count, 4);
    check("halt_overflow_sticky", out_overflow, 1);

    // Drain in DONE
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      if (out_empty) begin
        check("drain_underflow", out_empty, 0);
        break;
      end
      check("drain_data", out_data, sb.pop_front());
      out_rd_en = 1'b1;
      @(negedge clk);
    end
    out_rd_en = 1'b0;
    @(negedge clk);
    check("drain_empty", out_empty, 1);
    check("drain_sb_left", sb.size(), 0);

    // ---- Run 2: full program against the core model
    model_en = 1'b1;
    reg_a_init = a_val;
    sb.delete();
    foreach (exp_prog[i]) sb.push_back(exp_prog[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_overflow_clear", out_overflow, 0);
    check("restart_count_clear", out_count, 0);
    ok = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done && out_empty) begin
        ok = 1'b1;
        break;
      end
      if (!out_empty) begin
        if (sb.size() == 0) check("prog_extra_out", out_data, 3'bxxx);
        else                check("prog_out", out_data, sb.pop_front());
        out_rd_en = 1'b1;
      end else begin
        out_rd_en = 1'b0;
      end
      @(negedge clk);
    end
    out_rd_en = 1'b0;
    check("prog_finished", ok, 1);
    check("prog_outputs_left", sb.size(), 0);
    check("prog_done", done, 1);
    check("prog_overflow", out_overflow, 0);
    check("prog_timeout", timeout, 0);

    // ---- Run 3: core never halts
    model_en = 1'b0;
    tb_uo = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RegW) @(negedge clk);
    check("nohalt_run_busy", busy, 1);
`ifdef CHRONO_WATCHDOG_EN
    repeat (Timeout - 1) @(negedge clk);
    check("wd_before_busy", busy, 1);
    check("wd_before_timeout", timeout, 0);
    @(negedge clk);
    check("wd_done", done, 1);
    check("wd_timeout", timeout, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wd_timeout_cleared", timeout, 0);
    repeat (RegW) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    check("nohalt_still_busy", busy, 1);
    check("nohalt_done", done, 0);
    check("nohalt_timeout", timeout, 0);
`endif

    // ---- Reset mid-RUN with data in the FIFO
    tb_uo = {3'd0, 1'b0, 1'b1, 3'd6};
    @(negedge clk);
    tb_uo = {3'd0, 1'b0, 1'b1, 3'd2};
    @(negedge clk);
    tb_uo = '0;
    check("pre_reset_count", out_count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_core_ui", core_ui, 0);
    check("midrst_count", out_count, 0);
    check("midrst_empty", out_empty, 1);
    check("midrst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program memory is cleared by reset
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RegW) @(negedge clk);
    tb_uo = {3'd1, 5'b0};
    #1;
    check("rst_prog_cleared", core_ui, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
